// File: rtl/gb_capture.sv
// Game Boy video capture: synchronises the async pixel bus, tracks frame/line
// geometry, maps pixel codes through a palette and queues RGB565 pixels in a FWFT FIFO.
module gb_capture #(
   parameter int H_PIXELS    = 160,
   parameter int V_LINES     = 144,
   parameter int PIX_BITS    = 2,
   parameter logic [16*(2**PIX_BITS)-1:0] PALETTE = {16'hFFFF, 16'hAD55, 16'h52AA, 16'h0000},
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pixclk,
   input  logic                hsync,
   input  logic                vsync,
   input  logic [PIX_BITS-1:0] gb_d,
   input  logic                enable,
   input  logic                clr_err,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [15:0]         out_data,
   output logic                out_sof,
   output logic                out_eol,
   output logic                ovf,
   output logic                line_err,
   output logic [7:0]          frame_cnt
);

   localparam int XW = $clog2(H_PIXELS) + 1;
   localparam int YW = $clog2(V_LINES) + 1;
   localparam int SW = 3 + PIX_BITS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [XW-1:0] X_END  = XW'(H_PIXELS);
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_END  = YW'(V_LINES);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // All four bus signals travel through one shared chain so data stays aligned with its strobe.
   logic [SW-1:0] sync_q [SYNC_STAGES];
   logic          pclk_prev;

   logic                s_pclk, s_hsync, s_vsync, pix_evt;
   logic [PIX_BITS-1:0] s_code;

   assign s_pclk  = sync_q[SYNC_STAGES-1][SW-1];
   assign s_hsync = sync_q[SYNC_STAGES-1][SW-2];
   assign s_vsync = sync_q[SYNC_STAGES-1][SW-3];
   assign s_code  = sync_q[SYNC_STAGES-1][PIX_BITS-1:0];
   assign pix_evt = s_pclk & ~pclk_prev;

   // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         pclk_prev <= 1'b0;
      end else begin
         sync_q[0] <= {pixclk, hsync, vsync, gb_d};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         pclk_prev <= s_pclk;
      end
   end

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    frame_d;
   logic          take, geom_err, push_d, sof_d, eol_d;
   logic          push_q;
   logic [17:0]   push_word_q;

   // NOTE: every signal gets a default first, so no path through this block can infer a latch.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      frame_d  = frame_cnt;
      take     = 1'b0;
      geom_err = 1'b0;
      push_d   = 1'b0;
      sof_d    = 1'b0;
      eol_d    = 1'b0;
      if (pix_evt) begin
         case (state_q)
            IDLE: begin
               if (s_vsync && enable) begin
                  state_d = ACTIVE;
                  x_d     = '0;
                  y_d     = '0;
                  frame_d = frame_cnt + 8'd1;
                  take    = 1'b1;
               end
            end
            ACTIVE: begin
               if (s_vsync) begin
                  if (!enable) begin
                     state_d = IDLE;
                  end else begin
                     if (y_q != Y_LAST || x_q != X_END) geom_err = 1'b1;
                     x_d     = '0;
                     y_d     = '0;
                     frame_d = frame_cnt + 8'd1;
                     take    = 1'b1;
                  end
               end else begin
                  if (s_hsync) begin
                     if (x_q != X_END) geom_err = 1'b1;
                     x_d = '0;
                     y_d = (y_q >= Y_END) ? Y_END : y_q + 1'b1;
                  end
                  take = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         // Out-of-window pixels are dropped; x parks at H_PIXELS until the next line starts.
         if (take) begin
            if (y_d >= Y_END || x_d >= X_END) begin
               geom_err = 1'b1;
            end else begin
               push_d = 1'b1;
               sof_d  = (x_d == '0) && (y_d == '0);
               eol_d  = (x_d == X_LAST);
               x_d    = x_d + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         frame_cnt   <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         line_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         frame_cnt   <= frame_d;
         push_q      <= push_d;
         push_word_q <= {sof_d, eol_d, PALETTE[{s_code, 4'b0000} +: 16]};
         if (geom_err)     line_err <= 1'b1;
         else if (clr_err) line_err <= 1'b0;
      end
   end

   // Output FIFO, first-word-fall-through; pointers carry one wrap bit.
   logic [17:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full, rd_en, wr_en, drop;
   logic [17:0] head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = ~empty & out_ready;
   assign wr_en = push_q & (~full | rd_en);
   assign drop  = push_q & full & ~rd_en;

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (drop)         ovf <= 1'b1;
         else if (clr_err) ovf <= 1'b0;
      end
   end

   // Head is masked while empty so the outputs read zero out of reset.
   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_valid = ~empty;
   assign out_data  = out_valid ? head[15:0] : 16'h0000;
   assign out_eol   = out_valid & head[16];
   assign out_sof   = out_valid & head[17];

endmodule

// File: tb/tb_gb_capture.sv
// Directed bench for gb_capture on a reduced 8x6 geometry; expected pixel streams
// are built from the bench's own raster knowledge and a local copy of the palette.
`timescale 1ns/1ps
module tb_gb_capture;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int SS = 2;
   localparam int FD = 16;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       pixclk = 1'b0, hsync = 1'b0, vsync = 1'b0;
   logic [1:0] gb_d = 2'd0;
   logic       enable = 1'b0, clr_err = 1'b0, out_ready = 1'b0;
   logic       out_valid, out_sof, out_eol, ovf, line_err;
   logic [15:0] out_data;
   logic [7:0]  frame_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [17:0] got_q [$];
   logic [17:0] exp_q [$];
   logic [15:0] pal [4] = '{16'h0000, 16'h52AA, 16'hAD55, 16'hFFFF};

   gb_capture #(
      .H_PIXELS(H), .V_LINES(V), .PIX_BITS(2), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixclk(pixclk), .hsync(hsync), .vsync(vsync),
      .gb_d(gb_d), .enable(enable), .clr_err(clr_err), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
      .out_eol(out_eol), .ovf(ovf), .line_err(line_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back({out_sof, out_eol, out_data});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; pixclk = 1'b0; hsync = 1'b0; vsync = 1'b0; gb_d = 2'd0; clr_err = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send_pixel(input logic hs, input logic vs, input logic [1:0] d);
      pixclk = 1'b0; hsync = hs; vsync = vs; gb_d = d;
      tick(4);
      pixclk = 1'b1;
      tick(4);
   endtask

   task automatic send_line(input int y, input int n, input bit vs_first, input bit keep);
      for (int x = 0; x < n; x++) begin
         send_pixel(x == 0, vs_first && x == 0, 2'((x + y) % 4));
         if (keep && x < H && y < V)
            exp_q.push_back({(x == 0 && y == 0), (x == H - 1), pal[(x + y) % 4]});
      end
   endtask

   task automatic send_frame(input int lines, input bit keep);
      for (int y = 0; y < lines; y++) send_line(y, H, y == 0, keep);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      out_ready = 1'b1;
      tick(8);
      while (out_valid && t < 200) begin
         tick(1);
         t++;
      end
      n_checks++;
      if (out_valid) $display("FAIL %s drain: out_valid still 1 after %0d cycles, required 0", tag, t);
      else n_pass++;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({out_valid, out_sof, out_eol, ovf, line_err} !== 5'b0)
         $display("FAIL reset flags: got valid/sof/eol/ovf/err %b, required 00000",
                  {out_valid, out_sof, out_eol, ovf, line_err});
      else n_pass++;
      n_checks++;
      if (out_data !== 16'h0000) $display("FAIL reset out_data: got %h, required 0000", out_data);
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 8'd0) $display("FAIL reset frame_cnt: got %0d, required 0", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_latency();
      apply_reset();
      enable = 1'b1; out_ready = 1'b0;
      hsync = 1'b1; vsync = 1'b1; gb_d = 2'd3; pixclk = 1'b0;
      tick(4);
      pixclk = 1'b1;
      tick(SS + 1);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL latency early: out_valid %b after %0d edges, required 0", out_valid, SS + 1);
      else n_pass++;
      tick(1);
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL latency rise: out_valid %b after %0d edges, required 1", out_valid, SS + 2);
      else n_pass++;
      n_checks++;
      if ({out_sof, out_eol, out_data} !== {1'b1, 1'b0, 16'hFFFF})
         $display("FAIL latency head: got %h, required %h", {out_sof, out_eol, out_data}, {1'b1, 1'b0, 16'hFFFF});
      else n_pass++;
      tick(5);
      n_checks++;
      if ({out_valid, out_sof, out_eol, out_data} !== {1'b1, 1'b1, 1'b0, 16'hFFFF})
         $display("FAIL latency hold: got %h, required %h", {out_valid, out_sof, out_eol, out_data},
                  {1'b1, 1'b1, 1'b0, 16'hFFFF});
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 8'd1) $display("FAIL latency frame_cnt: got %0d, required 1", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_nominal();
      apply_reset();
      enable = 1'b1; out_ready = 1'b1;
      send_frame(V, 1'b1);
      drain("nominal");
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL nominal count: got %0d, required %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL nominal word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if ({frame_cnt, ovf, line_err} !== {8'd1, 2'b00})
         $display("FAIL nominal status: got cnt/ovf/err %0d/%b/%b, required 1/0/0", frame_cnt, ovf, line_err);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      apply_reset();
      enable = 1'b1; out_ready = 1'b0;
      send_line(0, H, 1'b1, 1'b1);
      send_line(1, H, 1'b0, 1'b1);
      send_line(2, 4, 1'b0, 1'b1);
      tick(8);
      n_checks++;
      if ({ovf, line_err} !== 2'b10) $display("FAIL backpressure flags: got ovf/err %b%b, required 10", ovf, line_err);
      else n_pass++;
      while (exp_q.size() > FD) void'(exp_q.pop_back());
      drain("backpressure");
      n_checks++;
      if (got_q.size() != FD) $display("FAIL backpressure count: got %0d, required %0d", got_q.size(), FD);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL backpressure word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (ovf !== 1'b1) $display("FAIL backpressure sticky: ovf %b, required 1", ovf);
      else n_pass++;
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      tick(1);
      n_checks++;
      if (ovf !== 1'b0) $display("FAIL backpressure clear: ovf %b, required 0", ovf);
      else n_pass++;
   endtask

   task automatic test_short_line();
      apply_reset();
      enable = 1'b1; out_ready = 1'b1;
      send_line(0, H, 1'b1, 1'b1);
      send_line(1, H, 1'b0, 1'b1);
      send_line(2, H - 2, 1'b0, 1'b1);
      tick(8);
      n_checks++;
      if (line_err !== 1'b0) $display("FAIL short before: line_err %b, required 0", line_err);
      else n_pass++;
      send_line(3, H, 1'b0, 1'b1);
      n_checks++;
      if (line_err !== 1'b1) $display("FAIL short after: line_err %b, required 1", line_err);
      else n_pass++;
      send_line(4, H, 1'b0, 1'b1);
      send_line(5, H, 1'b0, 1'b1);
      drain("short");
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL short count: got %0d, required %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL short word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_long_frame();
      apply_reset();
      enable = 1'b1; out_ready = 1'b1;
      send_frame(V + 2, 1'b1);
      tick(8);
      n_checks++;
      if (line_err !== 1'b1) $display("FAIL long flag: line_err %b, required 1", line_err);
      else n_pass++;
      send_line(0, H, 1'b1, 1'b1);
      drain("long");
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL long count: got %0d, required %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL long word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (frame_cnt !== 8'd2) $display("FAIL long frame_cnt: got %0d, required 2", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_enable();
      apply_reset();
      out_ready = 1'b1;
      enable = 1'b0;
      send_frame(V, 1'b0);
      drain("enable_off");
      n_checks++;
      if (got_q.size() != 0 || frame_cnt !== 8'd0)
         $display("FAIL enable off: got %0d outputs cnt %0d, required 0 outputs cnt 0", got_q.size(), frame_cnt);
      else n_pass++;
      enable = 1'b1;
      send_frame(V, 1'b1);
      drain("enable_on");
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL enable count: got %0d, required %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL enable word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      enable = 1'b0;
      send_frame(V, 1'b0);
      drain("enable_off2");
      n_checks++;
      if (got_q.size() != exp_q.size() || frame_cnt !== 8'd1 || line_err !== 1'b0)
         $display("FAIL enable regate: got %0d outputs cnt %0d err %b, required %0d outputs cnt 1 err 0",
                  got_q.size(), frame_cnt, line_err, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      enable = 1'b1; out_ready = 1'b1;
      send_frame(3, 1'b0);
      out_ready = 1'b0;
      send_line(3, 4, 1'b0, 1'b0);
      tick(4);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_sof, out_eol, out_data, frame_cnt} !== 27'd0)
         $display("FAIL midreset outputs: got valid %b data %h cnt %0d, required 0/0000/0", out_valid, out_data, frame_cnt);
      else n_pass++;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      got_q.delete();
      exp_q.delete();
      out_ready = 1'b1;
      send_line(4, H, 1'b0, 1'b0);
      send_line(5, H, 1'b0, 1'b0);
      drain("midreset_idle");
      n_checks++;
      if (got_q.size() != 0) $display("FAIL midreset idle: got %0d outputs, required 0", got_q.size());
      else n_pass++;
      send_frame(V, 1'b1);
      drain("midreset_next");
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL midreset count: got %0d, required %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL midreset word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if ({frame_cnt, line_err} !== {8'd1, 1'b0})
         $display("FAIL midreset status: got cnt/err %0d/%b, required 1/0", frame_cnt, line_err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_nominal();
      test_back_pressure();
      test_short_line();
      test_long_frame();
      test_enable();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
